// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, drives the instruction memory
// address, and fills the IF/ID pipeline register with the fetched word, its
// PC, a valid bit and an address-fault flag. Also counts valid fetches.
module if_fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr,
  output logic [31:0] F_pc,
  output logic [31:0] D_pc,
  output logic [31:0] D_instr,
  output logic        D_valid,
  output logic        D_exc,
  output logic [31:0] fetch_cnt
);

  // One past the last legal byte address, kept in 33 bits so a window that
  // ends exactly at 2^32 still compares correctly.
  localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + ({1'b0, 32'(IM_WORDS)} << 2);

  logic [31:0] pc_q, pc_d;
  logic [31:0] dPc_q, dPc_d;
  logic [31:0] dInstr_q, dInstr_d;
  logic        dValid_q, dValid_d;
  logic        dExc_q, dExc_d;
  logic [31:0] fetchCnt_q, fetchCnt_d;
  logic        fault;
  logic        load;

  assign im_addr   = pc_q;
  assign F_pc      = pc_q;
  assign D_pc      = dPc_q;
  assign D_instr   = dInstr_q;
  assign D_valid   = dValid_q;
  assign D_exc     = dExc_q;
  assign fetch_cnt = fetchCnt_q;

  // A fetch faults when misaligned or outside the instruction window.
  assign fault = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || ({1'b0, pc_q} >= IM_LIMIT);

  // A real load into IF/ID happens only when neither stalled nor flushed.
  assign load = !stall && !flush;

  // Next PC: stall holds (and swallows any redirect), else redirect, else +4.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (stall) begin
      pc_d = pc_q;
    end else if (redirect_valid) begin
      pc_d = redirect_pc;
    end
  end

  // Next IF/ID contents: flush beats stall; a faulting slot carries a zero word.
  always_comb begin
    dPc_d      = dPc_q;
    dInstr_d   = dInstr_q;
    dValid_d   = dValid_q;
    dExc_d     = dExc_q;
    fetchCnt_d = fetchCnt_q;
    if (flush) begin
      dPc_d    = 32'h0;
      dInstr_d = 32'h0;
      dValid_d = 1'b0;
      dExc_d   = 1'b0;
    end else if (load) begin
      dPc_d      = pc_q;
      dInstr_d   = fault ? 32'h0 : im_instr;
      dValid_d   = 1'b1;
      dExc_d     = fault;
      fetchCnt_d = fetchCnt_q + 32'd1;
    end
  end

  // State registers; reset wipes any pending redirect or stall effect.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= PC_RESET;
      dPc_q      <= 32'h0;
      dInstr_q   <= 32'h0;
      dValid_q   <= 1'b0;
      dExc_q     <= 1'b0;
      fetchCnt_q <= 32'h0;
    end else begin
      pc_q       <= pc_d;
      dPc_q      <= dPc_d;
      dInstr_q   <= dInstr_d;
      dValid_q   <= dValid_d;
      dExc_q     <= dExc_d;
      fetchCnt_q <= fetchCnt_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: a table of directed vectors, a
// reset-during-stall sequence, then randomized traffic against a model.
module tb_if_fetch_unit;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam int          IM_WORDS = 4096;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic [31:0] imAddr;
  logic [31:0] imInstr;
  logic [31:0] fPc;
  logic [31:0] dPc;
  logic [31:0] dInstr;
  logic        dValid;
  logic        dExc;
  logic [31:0] fetchCnt;
  logic [31:0] memKey;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        stall;
    logic        flush;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] expFpc;
    logic [31:0] expDpc;
    logic        expValid;
    logic        expExc;
    logic [31:0] expCnt;
  } vec_t;

  vec_t vecs[15];

  // Model state: what the fetch stage should hold after each edge.
  logic [31:0] mPc, mDpc, mDinstr, mCnt;
  logic        mValid, mExc;

  if_fetch_unit #(
    .PC_RESET(PC_RESET),
    .IM_BASE (IM_BASE),
    .IM_WORDS(IM_WORDS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .redirect_valid(redirectValid),
    .redirect_pc   (redirectPc),
    .im_addr       (imAddr),
    .im_instr      (imInstr),
    .F_pc          (fPc),
    .D_pc          (dPc),
    .D_instr       (dInstr),
    .D_valid       (dValid),
    .D_exc         (dExc),
    .fetch_cnt     (fetchCnt)
  );

  // Instruction memory stand-in: the word is the address scrambled by a key.
  assign imInstr = imAddr ^ memKey;

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mkVec(logic s, logic f, logic rv, logic [31:0] rpc,
                                 logic [31:0] eF, logic [31:0] eD, logic eV,
                                 logic eE, logic [31:0] eC);
    vec_t v;
    v.stall = s; v.flush = f; v.rv = rv; v.rpc = rpc;
    v.expFpc = eF; v.expDpc = eD; v.expValid = eV; v.expExc = eE; v.expCnt = eC;
    return v;
  endfunction

  function automatic bit isFault(logic [31:0] a);
    longint addr = longint'(a);
    longint lo   = longint'(IM_BASE);
    longint hi   = lo + 4 * longint'(IM_WORDS);
    return (addr % 4 != 0) || (addr < lo) || (addr >= hi);
  endfunction

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] eF, input logic [31:0] eD,
                             input logic [31:0] eI, input logic eV, input logic eE,
                             input logic [31:0] eC);
    checkField({tag, ".F_pc"}, fPc, eF);
    checkField({tag, ".im_addr"}, imAddr, eF);
    checkField({tag, ".D_pc"}, dPc, eD);
    checkField({tag, ".D_instr"}, dInstr, eI);
    checkField({tag, ".D_valid"}, {31'b0, dValid}, {31'b0, eV});
    checkField({tag, ".D_exc"}, {31'b0, dExc}, {31'b0, eE});
    checkField({tag, ".fetch_cnt"}, fetchCnt, eC);
  endtask

  // Drive one cycle's inputs away from the edge, then sample just after it.
  task automatic applyStimulus(input logic r, input logic s, input logic f, input logic rv,
                               input logic [31:0] rpc, input logic [31:0] key);
    @(negedge clk);
    reset = r; stall = s; flush = f; redirectValid = rv; redirectPc = rpc; memKey = key;
    @(posedge clk);
    #1;
  endtask

  // Advance the model by one edge from the stage's behavioural rules.
  task automatic stepModel(input logic r, input logic s, input logic f, input logic rv,
                           input logic [31:0] rpc, input logic [31:0] key);
    if (r) begin
      mPc = PC_RESET; mDpc = 0; mDinstr = 0; mValid = 0; mExc = 0; mCnt = 0;
      return;
    end
    if (f) begin
      mDpc = 0; mDinstr = 0; mValid = 0; mExc = 0;
    end else if (!s) begin
      mDpc    = mPc;
      mExc    = isFault(mPc);
      mDinstr = mExc ? 32'h0 : (mPc ^ key);
      mValid  = 1;
      mCnt    = mCnt + 1;
    end
    if (!s) mPc = rv ? rpc : mPc + 32'd4;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0; redirectValid = 1'b0;
    redirectPc = 32'h0; memKey = 32'h0;

    // Directed path: echo memory, instruction equals address when valid and clean.
    vecs[0]  = mkVec(0, 0, 0, 32'h0,    32'h3004, 32'h3000, 1, 0, 1);
    vecs[1]  = mkVec(0, 0, 0, 32'h0,    32'h3008, 32'h3004, 1, 0, 2);
    vecs[2]  = mkVec(1, 0, 0, 32'h0,    32'h3008, 32'h3004, 1, 0, 2);
    vecs[3]  = mkVec(1, 0, 1, 32'h5000, 32'h3008, 32'h3004, 1, 0, 2);
    vecs[4]  = mkVec(0, 0, 0, 32'h0,    32'h300C, 32'h3008, 1, 0, 3);
    vecs[5]  = mkVec(0, 0, 1, 32'h3100, 32'h3100, 32'h300C, 1, 0, 4);
    vecs[6]  = mkVec(0, 0, 1, 32'h3010, 32'h3010, 32'h3100, 1, 0, 5);
    vecs[7]  = mkVec(1, 1, 0, 32'h0,    32'h3010, 32'h0,    0, 0, 5);
    vecs[8]  = mkVec(0, 1, 0, 32'h0,    32'h3014, 32'h0,    0, 0, 5);
    vecs[9]  = mkVec(0, 0, 1, 32'h3002, 32'h3002, 32'h3014, 1, 0, 6);
    vecs[10] = mkVec(0, 0, 1, 32'h2FFC, 32'h2FFC, 32'h3002, 1, 1, 7);
    vecs[11] = mkVec(0, 0, 1, 32'h7000, 32'h7000, 32'h2FFC, 1, 1, 8);
    vecs[12] = mkVec(0, 0, 0, 32'h0,    32'h7004, 32'h7000, 1, 1, 9);
    vecs[13] = mkVec(0, 0, 1, 32'h6FFC, 32'h6FFC, 32'h7004, 1, 1, 10);
    vecs[14] = mkVec(0, 0, 0, 32'h0,    32'h7000, 32'h6FFC, 1, 0, 11);

    // Reset with every other control asserted must still give a clean state.
    applyStimulus(1, 1, 1, 1, 32'h1234_5678, 32'h0);
    checkOutput("reset", 32'h3000, 32'h0, 32'h0, 0, 0, 0);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(0, vecs[i].stall, vecs[i].flush, vecs[i].rv, vecs[i].rpc, 32'h0);
      checkOutput($sformatf("vec%0d", i), vecs[i].expFpc, vecs[i].expDpc,
                  (vecs[i].expValid && !vecs[i].expExc) ? vecs[i].expDpc : 32'h0,
                  vecs[i].expValid, vecs[i].expExc, vecs[i].expCnt);
    end

    // Reset arriving mid-stall with a redirect pending leaves nothing behind.
    applyStimulus(0, 1, 0, 1, 32'h4000, 32'h0);
    checkOutput("stallPend", 32'h7000, 32'h6FFC, 32'h6FFC, 1, 0, 11);
    applyStimulus(1, 1, 0, 1, 32'h4000, 32'h0);
    checkOutput("midReset", 32'h3000, 32'h0, 32'h0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    checkOutput("postReset", 32'h3004, 32'h3000, 32'h3000, 1, 0, 1);

    // Randomized traffic against the model, starting from a fresh reset.
    stepModel(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 32'h0, 32'h0);
    for (int n = 0; n < 400; n++) begin
      logic r, s, f, rv;
      logic [31:0] rpc, key;
      r   = ($urandom_range(0, 39) == 0);
      s   = ($urandom_range(0, 3) == 0);
      f   = ($urandom_range(0, 5) == 0);
      rv  = ($urandom_range(0, 3) == 0);
      key = $urandom;
      case ($urandom_range(0, 3))
        0:       rpc = IM_BASE + 4 * $urandom_range(0, IM_WORDS - 1);
        1:       rpc = IM_BASE + 4 * IM_WORDS - 4 * $urandom_range(0, 2);
        2:       rpc = IM_BASE - 4 * $urandom_range(0, 2) + $urandom_range(0, 3);
        default: rpc = $urandom;
      endcase
      stepModel(r, s, f, rv, rpc, key);
      applyStimulus(r, s, f, rv, rpc, key);
      checkOutput($sformatf("rand%0d", n), mPc, mDpc, mDinstr, mValid, mExc, mCnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h0000_3000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter IM_BASE, default 32'h0000_3000, meaning the lowest legal instruction byte address.
REQ-003 SHALL have parameter IM_WORDS, default 4096, meaning the number of legal instruction words starting at IM_BASE.
REQ-004 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port stall  input  1  hold the PC and hold the IF/ID register.
REQ-007 SHALL have port flush  input  1  replace the IF/ID contents with a bubble at the next edge.
REQ-008 SHALL have port redirect_valid  input  1  take redirect_pc as the next PC.
REQ-009 SHALL have port redirect_pc  input  32  branch/jump target byte address.
REQ-010 SHALL have port im_addr  output  32  byte address to instruction memory ADDR.
REQ-011 SHALL have port im_instr  input  32  instruction word returned combinationally by instruction memory.
REQ-012 SHALL have port F_pc  output  32  current fetch PC.
REQ-013 SHALL have ports D_pc (output, 32), D_instr (output, 32), D_valid (output, 1) and D_exc (output, 1), forming the IF/ID register: PC, instruction, slot valid, fetch fault.
REQ-014 SHALL have port fetch_cnt  output  32  count of valid fetches loaded into IF/ID.

Function
REQ-015 SHALL drive im_addr = F_pc combinationally, with zero-cycle memory latency.
REQ-016 SHALL update the PC with this priority: reset -> PC_RESET; else stall -> hold; else redirect_valid -> redirect_pc; else F_pc+4, modulo 2^32.
REQ-017 SHALL ignore redirect_valid while stall=1, so the requester holds redirect_valid until stall drops.
REQ-018 SHALL set fault = (F_pc[1:0]!=0) or F_pc<IM_BASE or F_pc>=IM_BASE+4*IM_WORDS, with the bound computed in 33 bits so no overflow occurs.
REQ-019 SHALL update IF/ID with this priority: reset -> bubble; else flush -> bubble (flush beats stall); else stall -> hold; else load.
REQ-020 SHALL define bubble as D_pc=0, D_instr=0, D_valid=0, D_exc=0.
REQ-021 SHALL define load as D_pc=F_pc, D_valid=1, D_exc=fault, and D_instr = (fault ? 32'h0 : im_instr).
REQ-022 SHALL increment fetch_cnt by 1 on each load edge, never on hold or bubble, and wrap from 32'hFFFF_FFFF to 0.
REQ-023 SHALL apply redirect and load on the same edge when redirect_valid=1, stall=0 and flush=0: the slot currently at F_pc (delay slot) enters IF/ID and F_pc becomes redirect_pc.
REQ-024 SHALL still advance or redirect the PC when flush=1 and stall=0; flush affects only IF/ID.
REQ-025 SHALL hold the PC and bubble IF/ID when flush=1 and stall=1.
REQ-026 SHALL NOT stop fetching on a fault; the PC keeps advancing and the fault is reported only through D_exc.

Reset
REQ-027 SHALL, at the first rising edge with reset=1, set F_pc=PC_RESET, IF/ID to bubble and fetch_cnt=0, regardless of the other inputs.
REQ-028 SHALL abandon any in-flight redirect or stall on reset, with no residual state.
REQ-029 SHALL present a valid load from PC_RESET at the first edge after reset deasserts, if stall=0.

Verification
REQ-030 SHALL be checked with scenario: reset, then 3 free-running cycles with im_instr echoing the address -> D_pc sequence 0x3000, 0x3004, 0x3008; fetch_cnt=3.
REQ-031 SHALL be checked with scenario: stall=1 for 2 cycles at F_pc=0x3008 -> F_pc and D_* unchanged for both edges; fetch_cnt unchanged.
REQ-032 SHALL be checked with scenario: redirect_valid=1 with redirect_pc=0x3100 at F_pc=0x300C -> next edge D_pc=0x300C, F_pc=0x3100; following edge D_pc=0x3100.
REQ-033 SHALL be checked with scenario: flush=1 and stall=1 together at F_pc=0x3010 -> D_valid=0, D_instr=0, F_pc stays 0x3010.
REQ-034 SHALL be checked with scenario: redirect to 0x3002, then to 0x2FFC, then to IM_BASE+4*IM_WORDS -> each load gives D_exc=1, D_instr=0, D_valid=1; PC continues +4.
REQ-035 SHALL be checked with scenario: reset asserted mid-stall with redirect pending -> F_pc=0x3000, D_valid=0, fetch_cnt=0 after one edge.
